iu_mul_sequencer: RTL and testbench
===================================

IU_MUL_SEQUENCER -- requirements
Module: iu_mul_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request to begin a multiply; sampled on clk rising edge.
- op  in  6  opcode: 6'b001010 UMUL, 6'b001011 SMUL, 6'b011010 UMULcc, 6'b011011 SMULcc.
- a  in  32  multiplier operand.
- b  in  32  multiplicand operand.
- ready  out  1  high when a start will be accepted.
- done  out  1  one-cycle pulse; result outputs are valid.
- rd_out  out  32  low word of the product.
- y_out  out  32  high word of the product (Y register value).
- y_we  out  1  Y register write enable, asserted with done.
- icc_out  out  4  {N,Z,V,C}.
- icc_we  out  1  icc write enable, asserted with done for cc ops only.
- op_err  out  1  one-cycle pulse when start is presented with an unsupported op.

Function
REQ-002 The FSM SHALL have states IDLE, MUL, FIX and DONE; ready SHALL be 1 only in IDLE.
REQ-003 A start is accepted at edge E0 when ready=1, start=1 and op is supported.
- a, b and op latched at E0.
- Later input changes SHALL have no effect on the operation in progress.
REQ-004 start with ready=0 SHALL be ignored: no state change, no op_err.
REQ-005 start with ready=1 and an unsupported op SHALL:
- not be accepted; FSM stays in IDLE.
- pulse op_err for exactly one cycle.
REQ-006 MUL SHALL perform 32 radix-2 shift-add iterations, one per cycle (edges E1..E32), on unsigned magnitudes.
- 5-bit iteration counter, cleared at E0.
- MUL exits when the counter wraps from 31.
REQ-007 Signed ops (SMUL, SMULcc):
- Magnitudes SHALL be |a| and |b| in 32-bit two's complement.
- 0x80000000 SHALL be treated as magnitude 2^31.
- FIX (edge E33) SHALL negate the 64-bit product iff a[31] XOR b[31].
- For unsigned ops, FIX SHALL pass the product through unchanged.
REQ-008 DONE SHALL occupy the cycle after E34.
- done=1 and y_we=1 for exactly that one cycle.
- rd_out = product[31:0], y_out = product[63:32].
- FSM returns to IDLE at E35; ready=1 from then on.
REQ-009 cc ops (UMULcc, SMULcc) SHALL set icc_we=1 in DONE and produce:
- N = product[31]
- Z = (product[31:0]==0)
- V = 0
- C = 0
REQ-010 For non-cc ops, icc_we SHALL be 0 and icc_out SHALL hold its previous value.
REQ-011 rd_out, y_out and icc_out SHALL hold their last values until the next DONE.
REQ-012 done, y_we, icc_we and op_err SHALL be 0 in every cycle not named in REQ-005 and REQ-008.
REQ-013 Accept-to-done latency SHALL be fixed at 35 cycles (E0 to done high), independent of operand values.

Reset
REQ-014 Asserting rst SHALL asynchronously:
- force state to IDLE;
- clear the iteration counter and the product accumulator;
- set rd_out, y_out = 0 and icc_out = 4'b0000;
- set done, y_we, icc_we, op_err = 0.
REQ-015 Reset during MUL or FIX SHALL abort the operation; no done, y_we or icc_we SHALL follow.
REQ-016 After rst deasserts, ready SHALL be 1 and the first start SHALL be accepted on the next rising edge.

Verification
REQ-017 UMUL, a=0xFFFFFFFF, b=0xFFFFFFFF -> done 35 cycles after accept; rd_out=0x00000001, y_out=0xFFFFFFFE, y_we=1, icc_we=0.
REQ-018 SMULcc, a=0xFFFFFFFF, b=0x00000001 -> rd_out=0xFFFFFFFF, y_out=0xFFFFFFFF, icc_out=4'b1000, icc_we=1.
REQ-019 UMULcc, a=0x00010000, b=0x00010000 -> rd_out=0x00000000, y_out=0x00000001, icc_out=4'b0100.
REQ-020 SMUL, a=0x80000000, b=0x80000000 -> rd_out=0x00000000, y_out=0x40000000; then SMUL a=0x80000000, b=0x00000001 -> rd_out=0x80000000, y_out=0xFFFFFFFF.
REQ-021 Accept UMUL, pulse rst 10 cycles later -> ready=1 after reset, no done within 40 cycles, all outputs 0.
REQ-022 Contention and bad op:
- Accept, then hold start=1 with new operands throughout busy -> single done with the original result; the next accept occurs at the first edge with ready=1.
- start with op=6'b000000 in IDLE -> op_err one-cycle pulse, ready stays 1.

Source files
------------

// File: rtl/iu_mul_sequencer.sv
// Sequential 32x32 integer multiplier (UMUL/SMUL/UMULcc/SMULcc).
// Radix-2 shift-add over magnitudes, sign fix-up, then a one-cycle result strobe.
module iu_mul_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic        done,
    output logic [31:0] rd_out,
    output logic [31:0] y_out,
    output logic        y_we,
    output logic [3:0]  icc_out,
    output logic        icc_we,
    output logic        op_err
);

    typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] mcand_q, mcand_d;
    logic        neg_q, neg_d;
    logic        cc_q, cc_d;
    logic [31:0] rd_q, rd_d;
    logic [31:0] y_q, y_d;
    logic [3:0]  icc_q, icc_d;
    logic        err_q, err_d;

    logic        op_ok, op_signed, op_cc;
    logic [31:0] a_mag, b_mag;
    logic [32:0] sum;

    always_comb begin
        op_ok     = 1'b0;
        op_signed = 1'b0;
        op_cc     = 1'b0;
        case (op)
            6'b001010: op_ok = 1'b1;
            6'b001011: begin op_ok = 1'b1; op_signed = 1'b1; end
            6'b011010: begin op_ok = 1'b1; op_cc = 1'b1; end
            6'b011011: begin op_ok = 1'b1; op_signed = 1'b1; op_cc = 1'b1; end
            default:   op_ok = 1'b0;
        endcase
        // 0x80000000 negates to itself, which is exactly the unsigned magnitude 2^31
        a_mag = (op_signed && a[31]) ? -a : a;
        b_mag = (op_signed && b[31]) ? -b : b;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        cc_d    = cc_q;
        rd_d    = rd_q;
        y_d     = y_q;
        icc_d   = icc_q;
        err_d   = 1'b0;
        sum     = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_ok) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        prod_d  = {32'd0, a_mag};
                        mcand_d = b_mag;
                        neg_d   = op_signed & (a[31] ^ b[31]);
                        cc_d    = op_cc;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MUL: begin
                sum    = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
                prod_d = {sum, prod_q[31:1]};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                // Two cycles: counter (wrapped to 0) selects negate step, then result load
                if (cnt_q == 5'd0) begin
                    if (neg_q) prod_d = -prod_q;
                    cnt_d = 5'd1;
                end else begin
                    state_d = DONE;
                    rd_d    = prod_q[31:0];
                    y_d     = prod_q[63:32];
                    if (cc_q) icc_d = {prod_q[31], (prod_q[31:0] == '0), 2'b00};
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            cc_q    <= 1'b0;
            rd_q    <= '0;
            y_q     <= '0;
            icc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            cc_q    <= cc_d;
            rd_q    <= rd_d;
            y_q     <= y_d;
            icc_q   <= icc_d;
            err_q   <= err_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign done    = (state_q == DONE);
    assign y_we    = done;
    assign icc_we  = done & cc_q;
    assign rd_out  = rd_q;
    assign y_out   = y_q;
    assign icc_out = icc_q;
    assign op_err  = err_q;

endmodule

// File: tb/tb_iu_mul_sequencer.sv
// Directed bench for iu_mul_sequencer with hand-computed products and flags.
module tb_iu_mul_sequencer;

    localparam logic [5:0] UMUL   = 6'b001010;
    localparam logic [5:0] SMUL   = 6'b001011;
    localparam logic [5:0] UMULCC = 6'b011010;
    localparam logic [5:0] SMULCC = 6'b011011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready, done, y_we, icc_we, op_err;
    logic [31:0] rd_out, y_out;
    logic [3:0]  icc_out;

    int total = 0;
    int bad   = 0;
    int lat;
    int hits;

    iu_mul_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .rd_out  (rd_out),
        .y_out   (y_out),
        .y_we    (y_we),
        .icc_out (icc_out),
        .icc_we  (icc_we),
        .op_err  (op_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an op for one edge (E0), optionally keep start high with new operands,
    // then return the number of negedge samples until done (35 expected).
    task automatic do_mul(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit hold, output int n);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        if (hold) begin
            a = ~x; b = y + 32'd1;
        end else begin
            start = 1'b0; a = 32'h1234_5678; b = 32'h9abc_def0;
        end
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (n == 10) chk("busy_ready", {63'd0, ready}, 64'd0);
        end
    endtask

    task automatic check_after_done(input string tag);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, {61'd0, done, y_we, icc_we}, 64'd0);
        chk({tag, "_ready"}, {63'd0, ready}, 64'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_state", {ready, done, y_we, icc_we, op_err, icc_out, y_out, rd_out},
            {5'b10000, 4'b0000, 32'd0, 32'd0});
        rst = 1'b0;

        // UMUL max operands
        do_mul(UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
        chk("umul_lat", lat, 35);
        chk("umul_res", {y_out, rd_out}, 64'hFFFF_FFFE_0000_0001);
        chk("umul_we", {62'd0, y_we, icc_we}, 64'b10);
        check_after_done("umul");

        // SMULcc -1 * 1
        do_mul(SMULCC, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        chk("smulcc_lat", lat, 35);
        chk("smulcc_res", {y_out, rd_out}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("smulcc_icc", {59'd0, icc_we, icc_out}, {59'd0, 1'b1, 4'b1000});
        check_after_done("smulcc");

        // UMULcc 2^16 * 2^16
        do_mul(UMULCC, 32'h0001_0000, 32'h0001_0000, 1'b0, lat);
        chk("umulcc_res", {y_out, rd_out}, 64'h0000_0001_0000_0000);
        chk("umulcc_icc", {59'd0, icc_we, icc_out}, {59'd0, 1'b1, 4'b0100});
        check_after_done("umulcc");

        // SMUL most-negative cases; icc must keep 0100 from the previous cc op
        do_mul(SMUL, 32'h8000_0000, 32'h8000_0000, 1'b0, lat);
        chk("smul_min2_res", {y_out, rd_out}, 64'h4000_0000_0000_0000);
        chk("smul_icc_hold", {59'd0, icc_we, icc_out}, {59'd0, 1'b0, 4'b0100});
        check_after_done("smul_min2");
        do_mul(SMUL, 32'h8000_0000, 32'h0000_0001, 1'b0, lat);
        chk("smul_min1_res", {y_out, rd_out}, 64'hFFFF_FFFF_8000_0000);
        chk("smul_min1_lat", lat, 35);
        check_after_done("smul_min1");
        chk("hold_after_done", {y_out, rd_out}, 64'hFFFF_FFFF_8000_0000);

        // Mixed-sign SMUL: -3 * 5 = -15
        do_mul(SMUL, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, lat);
        chk("smul_neg_res", {y_out, rd_out}, 64'hFFFF_FFFF_FFFF_FFF1);
        check_after_done("smul_neg");

        // Reset during MUL aborts the op
        @(negedge clk);
        start = 1'b1; op = UMUL; a = 32'd7; b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("rst_outputs", {ready, done, y_we, icc_we, op_err, icc_out, y_out, rd_out},
            {5'b10000, 4'b0000, 32'd0, 32'd0});
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {63'd0, ready}, 64'd1);
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || y_we || icc_we) hits++;
        end
        chk("rst_no_done", hits, 0);
        chk("rst_outputs_zero", {icc_out, y_out, rd_out}, 68'd0);

        // First start after reset is accepted immediately
        do_mul(UMUL, 32'd6, 32'd7, 1'b0, lat);
        chk("post_rst_lat", lat, 35);
        chk("post_rst_res", {y_out, rd_out}, 64'd42);
        check_after_done("post_rst");

        // Contention: start held high with new operands during busy
        do_mul(UMUL, 32'd3, 32'd5, 1'b1, lat);
        chk("cont_lat", lat, 35);
        chk("cont_res", {y_out, rd_out}, 64'd15);
        @(negedge clk);
        chk("cont_ready_e35", {62'd0, ready, done}, 64'b10);
        @(negedge clk);
        chk("cont_reaccept", {63'd0, ready}, 64'd0);
        #1 start = 1'b0;
        lat = 1;
        while (lat < 60 && !done) begin
            @(negedge clk);
            lat++;
        end
        chk("cont2_lat", lat, 35);
        chk("cont2_res", {y_out, rd_out}, 64'h0000_0005_FFFF_FFE8);
        check_after_done("cont2");

        // Unsupported op in IDLE
        @(negedge clk);
        start = 1'b1; op = 6'b000000; a = 32'd1; b = 32'd1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("operr_pulse", {62'd0, op_err, ready}, 64'b11);
        @(negedge clk);
        chk("operr_clear", {62'd0, op_err, ready}, 64'b01);
        chk("operr_no_done", {62'd0, done, y_we}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
